// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader FSM encoding and the error codes reported on err_code.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// The loader is the slave side; the host/memory environment is the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  import imem_loader_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Little-endian byte-to-word packer: the first byte shifted in lands in bits [7:0].
// word/word_done are valid combinationally in the cycle the final byte is shifted.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else if (shift) begin
      cnt <= cnt + 2'd1;
    end
  end

  // Data path carries no reset: only the byte count decides what is valid.
  always_ff @(posedge clk) begin
    if (shift) begin
      sr <= {data, sr[23:8]};
    end
  end

  assign word_done = shift && (cnt == 2'(WORD_BYTES - 1));
  assign word      = {data, sr};

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length/data/XOR-checksum byte frame, writes packed words
// to instruction memory at consecutive word addresses, and holds the CPU until a clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  input  logic          restart,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_error,
  output logic [1:0]    err_code
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state, state_next;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [ADDR_W:0]   wcnt;
  logic [1:0]        err_q;

  logic              accept;
  logic [15:0]       len_hdr;
  logic [15:0]       wnext;
  logic              pack_shift;
  logic              pack_clear;
  logic              do_restart;
  logic              word_done;
  logic [31:0]       word;

  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;

  assign bus.rx_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CSUM);
  assign accept  = bus.rx_valid && bus.rx_ready;
  assign len_hdr = {bus.rx_data, len_lo};
  assign wnext   = 16'(wcnt) + 16'd1;

  byte_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .shift     (pack_shift),
    .data      (bus.rx_data),
    .word_done (word_done),
    .word      (word)
  );

  always_comb begin
    state_next = state;
    pack_shift = 1'b0;
    pack_clear = 1'b0;
    do_restart = 1'b0;
    case (state)
      S_LEN_LO: if (accept) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (17'(len_hdr) > DEPTH_L) state_next = S_ERROR;
          else if (len_hdr == 16'd0)  state_next = S_CSUM;
          else                        state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          pack_shift = 1'b1;
          if (word_done && (wnext == len)) state_next = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) state_next = (bus.rx_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (restart) begin
          state_next = S_LEN_LO;
          pack_clear = 1'b1;
          do_restart = 1'b1;
        end
      end
      default: state_next = S_LEN_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_LEN_LO;
      len_lo <= 8'd0;
      len    <= 16'd0;
      csum   <= 8'd0;
      wcnt   <= '0;
      err_q  <= ERR_NONE;
    end else begin
      state <= state_next;
      if (accept && (state != S_CSUM)) csum <= csum ^ bus.rx_data;
      if (accept && (state == S_LEN_LO)) len_lo <= bus.rx_data;
      if (accept && (state == S_LEN_HI)) begin
        len <= len_hdr;
        if (17'(len_hdr) > DEPTH_L) err_q <= ERR_LEN;
      end
      if (accept && (state == S_CSUM) && (bus.rx_data != csum)) err_q <= ERR_CSUM;
      if (word_done) wcnt <= wcnt + {{ADDR_W{1'b0}}, 1'b1};
      if (do_restart) begin
        csum  <= 8'd0;
        wcnt  <= '0;
        err_q <= ERR_NONE;
      end
    end
  end

  // Stage p1: registered memory write, one cycle after the word's final byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= 32'd0;
    end else begin
      we_p1 <= word_done;
      if (word_done) begin
        addr_p1  <= wcnt[ADDR_W-1:0];
        wdata_p1 <= word;
      end
    end
  end

  assign bus.mem_we    = we_p1;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;

  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);
  assign cpu_hold   = (state != S_DONE);
  assign err_code   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad/oversize/empty frames, rx_valid gaps,
// restart and asynchronous reset in the middle of a load.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic       clk;
  logic       rst;
  logic       restart;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;
  logic [1:0] err_code;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  frame [16];
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          dup_cnt = 0;
  logic        prev_we = 1'b0;
  logic [9:0]  prev_addr = '0;

  imem_loader_if #(.ADDR_W(10)) bus ();

  imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .restart    (restart),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .err_code   (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      if (prev_we && (prev_addr == bus.mem_addr)) dup_cnt++;
    end
    prev_we   = bus.mem_we;
    prev_addr = bus.mem_addr;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_good(input logic [7:0] cs);
    frame[0] = 8'h02; frame[1] = 8'h00;
    frame[2] = 8'h13; frame[3] = 8'h00; frame[4] = 8'h50; frame[5] = 8'h00;
    frame[6] = 8'h93; frame[7] = 8'h00; frame[8] = 8'hA0; frame[9] = 8'h00;
    frame[10] = cs;
  endtask

  task automatic send_frame(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_data  = frame[i];
      bus.rx_valid = 1'b1;
      if (gap) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_good_writes(input string tag);
    checks++;
    if (wr_addr.size() !== 2) begin
      failures++;
      $display("FAIL %s_write_count: got %0d expected 2", tag, wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h00500013) begin
        failures++;
        $display("FAIL %s_word0: got %h@%0d expected 00500013@0", tag, wr_data[0], wr_addr[0]);
      end
      checks++;
      if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00A00093) begin
        failures++;
        $display("FAIL %s_word1: got %h@%0d expected 00a00093@1", tag, wr_data[1], wr_addr[1]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.rx_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'd0 ||
        bus.mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL %s_bus: rdy=%b we=%b addr=%0d wdata=%h expected 1 0 0 00000000",
               tag, bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 || err_code !== 2'b00) begin
      failures++;
      $display("FAIL %s_status: hold=%b done=%b err=%b code=%b expected 1 0 0 00",
               tag, cpu_hold, load_done, load_error, err_code);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("reset_asserted");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_good_load();
    set_good(8'h72);
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 5; i++) send_byte(frame[i]);
    checks++;
    if (bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL good_no_early_we: got %b expected 0", bus.mem_we);
    end
    send_byte(frame[5]);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== 32'h00500013) begin
      failures++;
      $display("FAIL good_we_latency: we=%b addr=%0d data=%h expected 1 0 00500013",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL good_we_single_cycle: got %b expected 0", bus.mem_we);
    end
    for (int i = 6; i < 11; i++) send_byte(frame[i]);
    check_good_writes("good");
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || bus.rx_ready !== 1'b0 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL good_status: done=%b hold=%b rdy=%b err=%b expected 1 0 0 0",
               load_done, cpu_hold, bus.rx_ready, load_error);
    end
  endtask

  task automatic test_bad_csum();
    pulse_restart();
    set_good(8'h73);
    send_frame(11, 1'b0);
    check_good_writes("badcs");
    checks++;
    if (load_error !== 1'b1 || err_code !== ERR_CSUM || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL badcs_status: err=%b code=%b hold=%b done=%b expected 1 10 1 0",
               load_error, err_code, cpu_hold, load_done);
    end
  endtask

  task automatic test_len_error();
    pulse_restart();
    frame[0] = 8'h01; frame[1] = 8'h04;
    send_frame(2, 1'b0);
    checks++;
    if (load_error !== 1'b1 || err_code !== ERR_LEN || bus.rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL len_status: err=%b code=%b rdy=%b hold=%b expected 1 01 0 1",
               load_error, err_code, bus.rx_ready, cpu_hold);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() !== 0) begin
      failures++;
      $display("FAIL len_no_write: got %0d writes expected 0", wr_addr.size());
    end
  endtask

  task automatic test_empty_load();
    pulse_restart();
    checks++;
    if (load_error !== 1'b0 || err_code !== ERR_NONE || bus.rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear: err=%b code=%b rdy=%b expected 0 00 1",
               load_error, err_code, bus.rx_ready);
    end
    frame[0] = 8'h00; frame[1] = 8'h00; frame[2] = 8'h00;
    send_frame(3, 1'b0);
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || wr_addr.size() !== 0) begin
      failures++;
      $display("FAIL empty_status: done=%b hold=%b writes=%0d expected 1 0 0",
               load_done, cpu_hold, wr_addr.size());
    end
  endtask

  task automatic test_gaps_and_restart();
    pulse_restart();
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL restart_hold: hold=%b done=%b expected 1 0", cpu_hold, load_done);
    end
    set_good(8'h72);
    send_frame(11, 1'b1);
    check_good_writes("gap");
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL gap_status: done=%b hold=%b expected 1 0", load_done, cpu_hold);
    end
    pulse_restart();
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0 || bus.rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reload_hold: hold=%b done=%b rdy=%b expected 1 0 1",
               cpu_hold, load_done, bus.rx_ready);
    end
    send_frame(11, 1'b0);
    check_good_writes("reload");
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL reload_status: done=%b hold=%b expected 1 0", load_done, cpu_hold);
    end
  endtask

  task automatic test_restart_ignored();
    set_good(8'h72);
    pulse_restart();
    send_frame(3, 1'b0);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    for (int i = 3; i < 11; i++) send_byte(frame[i]);
    check_good_writes("ignore");
    checks++;
    if (load_done !== 1'b1) begin
      failures++;
      $display("FAIL ignore_status: done=%b expected 1", load_done);
    end
  endtask

  task automatic test_mid_reset();
    pulse_restart();
    set_good(8'h72);
    send_frame(6, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    send_frame(11, 1'b0);
    check_good_writes("midrst_reload");
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL midrst_status: done=%b hold=%b expected 1 0", load_done, cpu_hold);
    end
    checks++;
    if (dup_cnt !== 0) begin
      failures++;
      $display("FAIL we_same_addr_repeat: got %0d repeats expected 0", dup_cnt);
    end
  endtask

  initial begin
    rst          = 1'b1;
    restart      = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_good_load();
    test_bad_csum();
    test_len_error();
    test_empty_load();
    test_gaps_and_restart();
    test_restart_ignored();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
